// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared instruction-field positions, history slot and hazard FSM types
package pipeline_pkg;
  localparam int REG_W  = 5;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             is_load;
  } hist_slot_t;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZARD = 2'd1,
    FROZEN = 2'd2
  } hz_state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: flags an in-flight destination that matches a source register of ID
module hazard_match
  import pipeline_pkg::*;
(
  input  hist_slot_t       i_slot,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  output logic             o_match
);
  assign o_match = (i_slot.dest != '0) && ((i_slot.dest == i_rs) || (i_slot.dest == i_rt));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage stall/bubble decision with two-deep destination history
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            ID_Instr,
  input  logic                   ID_Valid,
  input  logic                   ID_RegWrite,
  input  logic                   ID_RegDest,
  input  logic                   ID_MemRead,
  input  logic                   ID_UsesRt,
  input  logic                   ID_IsBranch,
  input  logic                   ID_ReadsHiLo,
  input  logic                   MD_Busy,
  input  logic                   EXT_FREEZE,
  output logic                   IF_Freeze,
  output logic                   ID_Freeze,
  output logic                   EXE_Bubble,
  output logic [1:0]             Hz_State,
  output logic [STALL_CNT_W-1:0] Stall_Cycles
);
  hist_slot_t             r_exe, r_mem;
  hz_state_t              r_state;
  logic [STALL_CNT_W-1:0] r_cnt;
  logic [REG_W-1:0]       w_rs, w_rt, w_dest;
  logic                   w_m_exe, w_m_mem, w_hazard, w_unused;
  hz_state_t              w_next;
  hist_slot_t             w_push;

  assign w_rs     = ID_Instr[RS_LSB +: REG_W];
  assign w_rt     = ID_UsesRt ? ID_Instr[RT_LSB +: REG_W] : '0;
  assign w_dest   = (ID_RegWrite && ID_Valid) ?
                    (ID_RegDest ? ID_Instr[RD_LSB +: REG_W] : ID_Instr[RT_LSB +: REG_W]) : '0;
  assign w_unused = ^{ID_Instr[31:26], ID_Instr[10:0]};

  hazard_match u_match_exe (.i_slot(r_exe), .i_rs(w_rs), .i_rt(w_rt), .o_match(w_m_exe));
  hazard_match u_match_mem (.i_slot(r_mem), .i_rs(w_rs), .i_rt(w_rt), .o_match(w_m_mem));

  // Branches resolve in ID, so any EXE producer stalls them; only loads stall them from MEM.
  assign w_hazard = ID_Valid && ((r_exe.is_load && w_m_exe) ||
                                 (ID_IsBranch && w_m_exe) ||
                                 (ID_IsBranch && r_mem.is_load && w_m_mem) ||
                                 (ID_ReadsHiLo && MD_Busy));

  assign IF_Freeze    = w_hazard || EXT_FREEZE;
  assign ID_Freeze    = w_hazard || EXT_FREEZE;
  assign EXE_Bubble   = w_hazard && !EXT_FREEZE;
  assign Hz_State     = r_state;
  assign Stall_Cycles = r_cnt;

  always_comb begin
    w_next = EXT_FREEZE ? FROZEN : (w_hazard ? HAZARD : RUN);
    w_push = w_hazard ? hist_slot_t'('0) : hist_slot_t'{w_dest, ID_MemRead && (w_dest != '0)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_exe   <= '0;
      r_mem   <= '0;
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (!EXT_FREEZE) begin
        r_mem <= r_exe;
        r_exe <= w_push;
      end
      if (EXE_Bubble && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a queued scoreboard checked on the falling edge
module tb_hazard_stall_ctrl;
  localparam logic [1:0] S_RUN = 2'd0, S_HAZ = 2'd1, S_FRZ = 2'd2;

  typedef struct {
    bit          frz;
    bit          bub;
    logic [1:0]  st;
    int          cnt;
    string       nm;
  } exp_t;

  logic        CLK = 0, RESET = 1;
  logic [31:0] ID_Instr = '0;
  logic        ID_Valid = 0, ID_RegWrite = 0, ID_RegDest = 0, ID_MemRead = 0;
  logic        ID_UsesRt = 0, ID_IsBranch = 0, ID_ReadsHiLo = 0, MD_Busy = 0, EXT_FREEZE = 0;
  logic        IF_Freeze, ID_Freeze, EXE_Bubble;
  logic [1:0]  Hz_State;
  logic [15:0] Stall_Cycles;

  exp_t q[$];
  int   tests = 0, fails = 0;

  hazard_stall_ctrl #(.STALL_CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid),
    .ID_RegWrite(ID_RegWrite), .ID_RegDest(ID_RegDest), .ID_MemRead(ID_MemRead),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .ID_ReadsHiLo(ID_ReadsHiLo),
    .MD_Busy(MD_Busy), .EXT_FREEZE(EXT_FREEZE), .IF_Freeze(IF_Freeze), .ID_Freeze(ID_Freeze),
    .EXE_Bubble(EXE_Bubble), .Hz_State(Hz_State), .Stall_Cycles(Stall_Cycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".if_freeze"}, int'(IF_Freeze), int'(e.frz));
      chk({e.nm, ".id_freeze"}, int'(ID_Freeze), int'(e.frz));
      chk({e.nm, ".bubble"}, int'(EXE_Bubble), int'(e.bub));
      chk({e.nm, ".state"}, int'(Hz_State), int'(e.st));
      chk({e.nm, ".cnt"}, int'(Stall_Cycles), e.cnt);
    end
  end

  task automatic set_id(input logic [4:0] rs, rt, rd, input bit v, rw, rdst, mr, urt, br, hl);
    ID_Instr     = {6'd0, rs, rt, rd, 11'd0};
    ID_Valid     = v;
    ID_RegWrite  = rw;
    ID_RegDest   = rdst;
    ID_MemRead   = mr;
    ID_UsesRt    = urt;
    ID_IsBranch  = br;
    ID_ReadsHiLo = hl;
  endtask

  task automatic i_nop();                                 set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic i_lw(input logic [4:0] rt, rs);          set_id(rs, rt, 0, 1, 1, 0, 1, 0, 0, 0); endtask
  task automatic i_alu(input logic [4:0] rd, rs, rt);     set_id(rs, rt, rd, 1, 1, 1, 0, 1, 0, 0); endtask
  task automatic i_beq(input logic [4:0] rs, rt);         set_id(rs, rt, 0, 1, 0, 0, 0, 1, 1, 0); endtask
  task automatic i_mflo(input logic [4:0] rd);            set_id(0, 0, rd, 1, 1, 1, 0, 0, 0, 1); endtask

  task automatic tick(input bit rst, ext, md, ef, eb, input logic [1:0] es, input int ec, input string nm);
    exp_t e;
    RESET = rst;
    EXT_FREEZE = ext;
    MD_Busy = md;
    e.frz = ef; e.bub = eb; e.st = es; e.cnt = ec; e.nm = nm;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    i_nop();
    RESET = 1; EXT_FREEZE = 0; MD_Busy = 0;
    @(posedge CLK);
    #1;
    RESET = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 0, "reset");
    // load-use with ALU consumer: one bubble
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "ld_alu0");
    i_alu(6, 5, 2);  tick(0, 0, 0, 1, 1, S_RUN, 0, "ld_alu1");
                     tick(0, 0, 0, 0, 0, S_HAZ, 1, "ld_alu2");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 1, "ld_alu3");
    // load then dependent branch: two bubbles
    do_reset();
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "ld_br0");
    i_beq(5, 2);     tick(0, 0, 0, 1, 1, S_RUN, 0, "ld_br1");
                     tick(0, 0, 0, 1, 1, S_HAZ, 1, "ld_br2");
                     tick(0, 0, 0, 0, 0, S_HAZ, 2, "ld_br3");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 2, "ld_br4");
    // ALU then dependent branch: one bubble
    do_reset();
    i_alu(5, 3, 4);  tick(0, 0, 0, 0, 0, S_RUN, 0, "alu_br0");
    i_beq(5, 2);     tick(0, 0, 0, 1, 1, S_RUN, 0, "alu_br1");
                     tick(0, 0, 0, 0, 0, S_HAZ, 1, "alu_br2");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 1, "alu_br3");
    // register 0 and independent consumers never stall
    do_reset();
    i_lw(0, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "r0_0");
    i_alu(6, 0, 0);  tick(0, 0, 0, 0, 0, S_RUN, 0, "r0_1");
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "indep0");
    i_alu(6, 7, 8);  tick(0, 0, 0, 0, 0, S_RUN, 0, "indep1");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 0, "indep2");
    // bubble in ID with matching fields must not stall
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "bub0");
    set_id(5, 5, 0, 0, 0, 0, 0, 1, 1, 0);
                     tick(0, 0, 0, 0, 0, S_RUN, 0, "bub1");
    // mflo while multiply/divide busy for 5 cycles
    do_reset();
    i_mflo(9);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 1, 1, (i == 0) ? S_RUN : S_HAZ, i, "hilo");
                     tick(0, 0, 0, 0, 0, S_HAZ, 5, "hilo_rel");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 5, "hilo_end");
    // external freeze over the first stall of a load-branch pair
    do_reset();
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "frz0");
    i_beq(5, 2);     tick(0, 1, 0, 1, 0, S_RUN, 0, "frz1");
                     tick(0, 1, 0, 1, 0, S_FRZ, 0, "frz2");
                     tick(0, 1, 0, 1, 0, S_FRZ, 0, "frz3");
                     tick(0, 0, 0, 1, 1, S_FRZ, 0, "frz4");
                     tick(0, 0, 0, 1, 1, S_HAZ, 1, "frz5");
                     tick(0, 0, 0, 0, 0, S_HAZ, 2, "frz6");
    i_nop();         tick(0, 0, 0, 0, 0, S_RUN, 2, "frz7");
    // reset during the second stall of a load-branch pair
    do_reset();
    i_lw(5, 1);      tick(0, 0, 0, 0, 0, S_RUN, 0, "rst0");
    i_beq(5, 2);     tick(0, 0, 0, 1, 1, S_RUN, 0, "rst1");
                     tick(1, 0, 0, 1, 1, S_HAZ, 1, "rst2");
                     tick(0, 0, 0, 0, 0, S_RUN, 0, "rst3");
    // counter saturation
    do_reset();
    i_mflo(9);
    for (int i = 0; i < 65535; i++) tick(0, 0, 1, 1, 1, (i == 0) ? S_RUN : S_HAZ, i, "sat_ramp");
                     tick(0, 0, 1, 1, 1, S_HAZ, 65535, "sat_hold0");
                     tick(0, 0, 1, 1, 1, S_HAZ, 65535, "sat_hold1");
                     tick(0, 0, 0, 0, 0, S_HAZ, 65535, "sat_rel");
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard scheduler for the 5-stage core. It sits beside the forwarding logic in the ID stage and decides when the instruction in ID cannot proceed, because forwarding cannot yet supply an operand: load-use, branch compare against an in-flight result, or HI/LO read while the multiply/divide unit is busy. It freezes IF/ID, inserts a bubble into EXE, tracks its own two-deep history of in-flight destination registers, and keeps a saturating stall-cycle counter for performance reporting.

## Interface
- `STALL_CNT_W`, 16, width of the stall-cycle counter.

- `CLK` in 1: core clock, rising edge.
- `RESET` in 1: synchronous, active-high; clears all state.
- `ID_Instr` in 32: instruction currently in ID.
- `ID_Valid` in 1: ID holds a real instruction (0 = bubble).
- `ID_RegWrite` in 1: instruction writes a GPR.
- `ID_RegDest` in 1: destination is `[15:11]` (1) or `[20:16]` (0).
- `ID_MemRead` in 1: instruction is a load.
- `ID_UsesRt` in 1: instruction reads rt as a source.
- `ID_IsBranch` in 1: instruction compares operands in ID (beq/bne/blez/bgtz/jr/jalr).
- `ID_ReadsHiLo` in 1: instruction is mfhi/mflo.
- `MD_Busy` in 1: the multiply/divide unit is computing.
- `EXT_FREEZE` in 1: global freeze from memory or cache; has priority over everything else.
- `IF_Freeze` out 1: hold PC and the IF/ID register.
- `ID_Freeze` out 1: hold the ID stage.
- `EXE_Bubble` out 1: load a NOP into ID/EXE.
- `Hz_State` out 2: FSM state, encoded RUN=0, HAZARD=1, FROZEN=2.
- `Stall_Cycles` out `STALL_CNT_W`: count of hazard bubble cycles.

## Operation
- Decode:
  - rs = `Instr[25:21]`.
  - rt = `Instr[20:16]` when `ID_UsesRt` is 1, else 0.
  - dest = `ID_RegDest ? [15:11] : [20:16]`. dest is forced to 0 when `!ID_RegWrite` or `!ID_Valid`.
  - Register 0 never creates a hazard.
- History: two slots, EXE and MEM. Each slot holds {dest[4:0], is_load}.
- match(slot) = slot.dest ≠ 0 and (slot.dest == rs or slot.dest == rt).
- hazard = `ID_Valid` and any of the following:
  - load_use: EXE.is_load and match(EXE).
  - br_exe: `ID_IsBranch` and match(EXE), whatever the producer type.
  - br_mem_ld: `ID_IsBranch` and MEM.is_load and match(MEM).
  - hilo: `ID_ReadsHiLo` and `MD_Busy`.
- Outputs (combinational from history and current ID inputs):
  - `IF_Freeze` = `ID_Freeze` = hazard or `EXT_FREEZE`.
  - `EXE_Bubble` = hazard and not `EXT_FREEZE`.
- History update on each clock edge:
  - `EXT_FREEZE`: both slots hold.
  - hazard: MEM ← EXE, EXE ← {0, 0} (bubble).
  - otherwise: MEM ← EXE, EXE ← {dest, `ID_MemRead` and dest≠0}.
- Resulting stall lengths:
  - Load followed by a dependent ALU op: 1 stall.
  - Load followed by a dependent branch: 2 stalls (load_use or br_exe, then br_mem_ld).
  - ALU op followed by a dependent branch: 1 stall.
- FSM, next state:
  - FROZEN if `EXT_FREEZE`.
  - else HAZARD if hazard.
  - else RUN.
  - Every state can reach every state.
- `Stall_Cycles` increments by 1 on each edge where hazard is true and `EXT_FREEZE` is not. It saturates at all-ones and never wraps.

## Timing
- Reset: on an edge with `RESET`=1, both slots become {0, 0}, `Hz_State` becomes RUN and `Stall_Cycles` becomes 0.
- After reset, only hilo or `EXT_FREEZE` can assert the freeze outputs.
- Decision latency is 0 cycles: the freeze outputs are valid in the same cycle as the ID inputs.
- `Hz_State` and `Stall_Cycles` are registered, so they lag the hazard by 1 cycle.
- `EXT_FREEZE` during a hazard:
  - No bubble is inserted and the history holds.
  - The hazard re-evaluates after release, so the stall still completes with the correct length.
- `RESET` asserted mid-stall: reset wins. The next cycle is RUN, with empty history.
- A bubble in ID (`ID_Valid`=0) never stalls and pushes dest 0 into history.

## Structure
- Shared package `pipeline_pkg` holds:
  - the hist_slot_t struct {dest, is_load};
  - the hz_state_t enum;
  - localparams for rs, rt and rd field positions, shared with the forwarding logic.
- One sub-module, `hazard_match`: a combinational comparator taking a slot, rs and rt, returning match. Instantiated twice (EXE, MEM).

## Test plan
- `lw $5,0($1)` then `add $6,$5,$2`:
  - Exactly 1 cycle with `EXE_Bubble`=1 and `IF_Freeze`=1.
  - `Stall_Cycles`=1.
  - `add` enters EXE with the load in MEM.
- `lw $5` then `beq $5,$2`: 2 consecutive stall cycles, `Stall_Cycles`=2. `add $5` then `beq $5,$2`: 1 stall cycle.
- `lw $0` then `add $6,$0,$0`, and `lw $5` then `add $6,$7,$8`: no stall, `Stall_Cycles` stays 0.
- `mflo` with `MD_Busy` high for 5 cycles:
  - 5 stall cycles, `Stall_Cycles`=5.
  - `Hz_State`=HAZARD for 5 cycles, then RUN.
- `lw $5`/`beq $5` with `EXT_FREEZE` high for 3 cycles starting in the first stall cycle:
  - `EXE_Bubble`=0 and the history holds while frozen.
  - `Hz_State`=FROZEN.
  - After release, exactly 2 bubbles in total.
- `RESET` asserted during the second stall of a load–branch pair: the next cycle has no freeze, the history is empty and `Stall_Cycles`=0. Preload `Stall_Cycles` to 0xFFFF, then cause a stall: it stays 0xFFFF.
